branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Branch resolution controller for the pipelined RV32I core; sits in EX beside the branch comparator.
- Decodes branch funct3, drives the comparator's signed/unsigned select and turns less/equal into a taken decision.
- Detects direction mispredicts against a 2-bit BHT it owns and issues a registered flush/redirect to IF/ID.
- Provides the IF-stage BHT lookup and two performance counters.

Parameters:
IDX_W, 6, BHT index width; BHT has 2^IDX_W entries.
CNT_W, 32, performance counter width.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_if_pc  in  32  IF-stage PC for BHT lookup
o_if_pred_taken  out  1  predicted direction for i_if_pc, combinational
i_ex_valid  in  1  EX holds a valid instruction
i_ex_is_branch  in  1  EX instruction is a conditional branch
i_ex_stall  in  1  EX held this cycle
i_ex_funct3  in  3  branch funct3
i_ex_pc  in  32  branch PC
i_ex_target  in  32  computed branch target
i_ex_pred_taken  in  1  prediction carried down the pipe
o_br_unsigned  out  1  comparator I_U select, 1 = unsigned
i_less  in  1  comparator less result
i_equal  in  1  comparator equal result
o_flush  out  1  kill IF/ID/EX wrong-path instructions
o_redirect_valid  out  1  load o_redirect_pc into PC
o_redirect_pc  out  32  corrected fetch address
o_illegal  out  1  branch with funct3 010/011 seen
o_br_cnt  out  CNT_W  resolved branches
o_mispred_cnt  out  CNT_W  mispredicted branches

Behaviour:
- Async reset: FSM=RUN. o_flush, o_redirect_valid, o_illegal = 0. o_redirect_pc = 0. Counters = 0. All BHT entries = 2'b01 (weakly not-taken). Reset mid-redirect drops the pending redirect.
- o_br_unsigned = i_ex_funct3[1], combinational, regardless of valid.
- Taken decode:
  - 000 = equal; 001 = !equal.
  - 100/110 = less; 101/111 = !less.
  - 010/011 = not taken, and o_illegal pulses 1 cycle (registered).
- resolve = i_ex_valid & i_ex_is_branch & !i_ex_stall & (state == RUN).
- actual = taken decode result; next_pc = actual ? i_ex_target : i_ex_pc + 32'd4 (wraps mod 2^32).
- On resolve:
  - o_br_cnt increments.
  - If actual != i_ex_pred_taken:
    - o_mispred_cnt increments.
    - Next cycle: o_flush = 1, o_redirect_valid = 1, o_redirect_pc = next_pc, FSM -> FLUSH.
  - BHT update:
    - Entry index = i_ex_pc[IDX_W+1:2].
    - Saturating: taken increments up to 11; not-taken decrements down to 00.
  - An illegal funct3 still updates counters and the BHT as not-taken.
- FSM:
  - RUN: stays in RUN unless resolve with mispredict -> FLUSH.
  - FLUSH: lasts exactly 1 cycle, during which o_flush/o_redirect_valid are high. EX content is wrong-path, so no resolve, no BHT update, no counter change. Then -> RUN.
- o_flush/o_redirect_valid are 1-cycle pulses. They are independent of i_ex_stall in FLUSH.
- Correct prediction: no flush, no redirect.
- BHT read: o_if_pred_taken = BHT[i_if_pc[IDX_W+1:2]][1].
  - Read in the same cycle as an update to the same entry returns the old value.
- Stall: while i_ex_stall = 1, the held branch is not resolved. It resolves exactly once, in the first unstalled cycle.
- Counters wrap at 2^CNT_W.
- Non-branch or invalid EX: no effect.

Test Plan:
- Reset, then read i_if_pc = 0x100 -> o_if_pred_taken = 0; all outputs 0.
- BEQ (000), pc = 0x100, target = 0x180, equal = 1, pred = 0 -> next cycle: flush = 1, redirect_valid = 1, redirect_pc = 0x180; mispred_cnt = 1; entry 0 goes to 10, so IF lookup of 0x100 now predicts 1. The following cycle, a valid branch in EX is ignored and br_cnt stays 1.
- BLTU (110), less = 1, pred = 1, pc = 0x200 -> o_br_unsigned = 1, no flush, br_cnt increments, mispred_cnt unchanged. BGE (101), less = 1, pred = 0 -> not taken, no flush, o_br_unsigned = 0.
- BNE held with i_ex_stall = 1 for 3 cycles, equal = 0, pred = 0, target = 0x40 -> single flush/redirect to 0x40 after the stall drops; br_cnt increments by exactly 1.
- Four taken resolutions at pc = 0x10 -> counter saturates at 11. One not-taken -> 10, still predicts taken. funct3 = 011 -> o_illegal pulse, treated as not-taken.
- Assert i_reset during the FLUSH cycle -> flush/redirect drop immediately; BHT reads 01 everywhere; counters = 0. Mispredicted BNE at pc = 0xFFFFFFFC, not taken -> redirect_pc = 0x00000000.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// Signal bundle between the EX/IF pipeline stages and the branch controller.
// Handshake: there is no valid/ready pair here; EX presents a branch with
// i_ex_valid & i_ex_is_branch and holds it while i_ex_stall is high. The
// controller consumes it in the first unstalled RUN cycle, and always accepts
// it there. Flush/redirect are single-cycle pulses that the pipeline must take.
interface branch_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic [31:0]      i_if_pc;
  logic             o_if_pred_taken;
  logic             i_ex_valid;
  logic             i_ex_is_branch;
  logic             i_ex_stall;
  logic [2:0]       i_ex_funct3;
  logic [31:0]      i_ex_pc;
  logic [31:0]      i_ex_target;
  logic             i_ex_pred_taken;
  logic             o_br_unsigned;
  logic             i_less;
  logic             i_equal;
  logic             o_flush;
  logic             o_redirect_valid;
  logic [31:0]      o_redirect_pc;
  logic             o_illegal;
  logic [CNT_W-1:0] o_br_cnt;
  logic [CNT_W-1:0] o_mispred_cnt;
  logic             o_dbg_state;   // 1 = FLUSH, 0 = RUN

  modport master (
    output i_if_pc, i_ex_valid, i_ex_is_branch, i_ex_stall, i_ex_funct3,
           i_ex_pc, i_ex_target, i_ex_pred_taken, i_less, i_equal,
    input  o_if_pred_taken, o_br_unsigned, o_flush, o_redirect_valid,
           o_redirect_pc, o_illegal, o_br_cnt, o_mispred_cnt, o_dbg_state
  );

  modport slave (
    input  i_if_pc, i_ex_valid, i_ex_is_branch, i_ex_stall, i_ex_funct3,
           i_ex_pc, i_ex_target, i_ex_pred_taken, i_less, i_equal,
    output o_if_pred_taken, o_br_unsigned, o_flush, o_redirect_valid,
           o_redirect_pc, o_illegal, o_br_cnt, o_mispred_cnt, o_dbg_state
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution controller: decodes branch funct3, resolves direction,
// detects mispredicts against a 2-bit BHT and issues a 1-cycle flush/redirect.
module branch_ctrl #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  branch_ctrl_if.slave   bus
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_bht [DEPTH];
  logic [31:0]      r_redirect_pc;
  logic             r_illegal;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic             w_taken;
  logic             w_illegal;
  logic             w_resolve;
  logic             w_mispred;
  logic [31:0]      w_next_pc;
  logic [IDX_W-1:0] w_upd_idx;
  logic [IDX_W-1:0] w_if_idx;
  logic             w_unused;

  assign w_upd_idx = bus.i_ex_pc[IDX_W+1:2];
  assign w_if_idx  = bus.i_if_pc[IDX_W+1:2];
  assign w_unused  = ^{bus.i_if_pc[31:IDX_W+2], bus.i_if_pc[1:0],
                       bus.i_ex_pc[1:0]};

  // Decode funct3 into a taken decision; 010/011 are not branches and fall
  // through as not-taken so the BHT and counters still see a resolution.
  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (bus.i_ex_funct3)
      3'b000:         w_taken = bus.i_equal;
      3'b001:         w_taken = !bus.i_equal;
      3'b100, 3'b110: w_taken = bus.i_less;
      3'b101, 3'b111: w_taken = !bus.i_less;
      default:        w_illegal = 1'b1;
    endcase
  end

  assign w_resolve = bus.i_ex_valid & bus.i_ex_is_branch & !bus.i_ex_stall &
                     (r_state == ST_RUN);
  assign w_mispred = w_resolve & (w_taken != bus.i_ex_pred_taken);
  assign w_next_pc = w_taken ? bus.i_ex_target : bus.i_ex_pc + 32'd4;

  assign bus.o_br_unsigned   = bus.i_ex_funct3[1];
  assign bus.o_if_pred_taken = r_bht[w_if_idx][1];
  assign bus.o_redirect_pc   = r_redirect_pc;
  assign bus.o_illegal       = r_illegal;
  assign bus.o_br_cnt        = r_br_cnt;
  assign bus.o_mispred_cnt   = r_mispred_cnt;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  // Next state: a mispredict costs exactly one FLUSH cycle.
  always_comb begin
    w_state_nxt = ST_RUN;
    if (r_state == ST_RUN && w_mispred) w_state_nxt = ST_FLUSH;
  end

  // Outputs from state: flush/redirect are high only in the FLUSH cycle, so a
  // reset during FLUSH drops them immediately.
  always_comb begin
    bus.o_flush          = (r_state == ST_FLUSH);
    bus.o_redirect_valid = (r_state == ST_FLUSH);
    bus.o_dbg_state      = (r_state == ST_FLUSH);
  end

  // Redirect target, illegal pulse and performance counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_redirect_pc <= 32'd0;
      r_illegal     <= 1'b0;
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_illegal <= w_resolve & w_illegal;
      if (w_resolve) r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_mispred) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        r_redirect_pc <= w_next_pc;
      end
    end
  end

  // BHT: saturating 2-bit counters, reset to weakly not-taken.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_bht[i] <= 2'b01;
    end else if (w_resolve) begin
      if (w_taken && r_bht[w_upd_idx] != 2'b11)
        r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
      else if (!w_taken && r_bht[w_upd_idx] != 2'b00)
        r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl against a behavioural reference model.
module tb_branch_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  branch_ctrl_if #(.CNT_W(32)) bus ();
  branch_ctrl #(.IDX_W(6), .CNT_W(32)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  int          m_bht [64];
  bit          m_flushing;
  logic [31:0] m_br;
  logic [31:0] m_mis;
  bit          e_flush;
  bit          e_ill;
  logic [31:0] e_rpc;
  logic [31:0] exp_q[$];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  // Branch semantics: base relation is equality (funct3[2]=0) or less-than,
  // funct3[0] negates it; funct3 01x is not a branch.
  function automatic bit ref_taken(input logic [2:0] f3, input bit lt, input bit eq);
    bit base;
    if (f3 == 3'd2 || f3 == 3'd3) return 1'b0;
    base = (f3 >= 3'd4) ? lt : eq;
    return (f3 % 2 == 1) ? !base : base;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_flushing = 0; m_br = 0; m_mis = 0;
    e_flush = 0; e_ill = 0; e_rpc = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    bit          resolve, tk;
    int          ix;
    resolve = bus.i_ex_valid && bus.i_ex_is_branch && !bus.i_ex_stall && !m_flushing;
    e_flush = 0;
    e_ill   = 0;
    if (resolve) begin
      tk = ref_taken(bus.i_ex_funct3, bus.i_less, bus.i_equal);
      m_br = m_br + 1;
      e_ill = (bus.i_ex_funct3 == 3'd2 || bus.i_ex_funct3 == 3'd3);
      if (tk != bus.i_ex_pred_taken) begin
        m_mis   = m_mis + 1;
        e_flush = 1;
        e_rpc   = tk ? bus.i_ex_target : bus.i_ex_pc + 32'd4;
      end
      ix = idx_of(bus.i_ex_pc);
      m_bht[ix] = tk ? ((m_bht[ix] < 3) ? m_bht[ix] + 1 : 3)
                     : ((m_bht[ix] > 0) ? m_bht[ix] - 1 : 0);
    end
    m_flushing = e_flush;
  endtask

  // Driver tasks
  task automatic set_ex(input bit v, input bit b, input bit s, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] tgt, input bit pred,
                        input bit lt, input bit eq);
    bus.i_ex_valid = v; bus.i_ex_is_branch = b; bus.i_ex_stall = s;
    bus.i_ex_funct3 = f3; bus.i_ex_pc = pc; bus.i_ex_target = tgt;
    bus.i_ex_pred_taken = pred; bus.i_less = lt; bus.i_equal = eq;
  endtask

  task automatic idle();
    set_ex(0, 0, 0, 3'd0, 32'd0, 32'd0, 0, 0, 0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.i_if_pc = 32'h100;
    model_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_if_pred_taken !== 1'b0 || bus.o_flush !== 1'b0 || bus.o_redirect_valid !== 1'b0 ||
        bus.o_illegal !== 1'b0 || bus.o_redirect_pc !== 32'd0 || bus.o_br_cnt !== 32'd0 ||
        bus.o_mispred_cnt !== 32'd0 || bus.o_dbg_state !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: pred=%b flush=%b rv=%b ill=%b rpc=%h br=%0d mis=%0d st=%b, required all 0",
               bus.o_if_pred_taken, bus.o_flush, bus.o_redirect_valid, bus.o_illegal,
               bus.o_redirect_pc, bus.o_br_cnt, bus.o_mispred_cnt, bus.o_dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_beq_mispredict();
    set_ex(1, 1, 0, 3'b000, 32'h100, 32'h180, 0, 0, 1);
    #1;
    n_cmp++;
    if (bus.o_br_unsigned !== 1'b0) begin
      n_bad++; $display("FAIL beq_unsigned: got %b required 0", bus.o_br_unsigned);
    end
    tick();
    bus.i_if_pc = 32'h100;
    #1;
    n_cmp++;
    if (bus.o_flush !== 1'b1 || bus.o_redirect_valid !== 1'b1 || bus.o_redirect_pc !== 32'h180 ||
        bus.o_mispred_cnt !== 32'd1 || bus.o_br_cnt !== 32'd1 || bus.o_dbg_state !== 1'b1) begin
      n_bad++;
      $display("FAIL beq_flush: flush=%b rv=%b rpc=%h mis=%0d br=%0d st=%b required 1 1 00000180 1 1 1",
               bus.o_flush, bus.o_redirect_valid, bus.o_redirect_pc, bus.o_mispred_cnt,
               bus.o_br_cnt, bus.o_dbg_state);
    end
    n_cmp++;
    if (bus.o_if_pred_taken !== 1'b1) begin
      n_bad++; $display("FAIL beq_bht_taken: got %b required 1", bus.o_if_pred_taken);
    end
    // Wrong-path branch sitting in EX during FLUSH must be ignored.
    tick();
    n_cmp++;
    if (bus.o_flush !== 1'b0 || bus.o_redirect_valid !== 1'b0 || bus.o_br_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL flush_ignores_ex: flush=%b rv=%b br=%0d required 0 0 1",
               bus.o_flush, bus.o_redirect_valid, bus.o_br_cnt);
    end
    idle();
    tick();
  endtask

  task automatic test_lt_ge();
    set_ex(1, 1, 0, 3'b110, 32'h200, 32'h280, 1, 1, 0);
    #1;
    n_cmp++;
    if (bus.o_br_unsigned !== 1'b1) begin
      n_bad++; $display("FAIL bltu_unsigned: got %b required 1", bus.o_br_unsigned);
    end
    tick();
    n_cmp++;
    if (bus.o_flush !== 1'b0 || bus.o_br_cnt !== m_br || bus.o_mispred_cnt !== m_mis ||
        bus.o_br_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL bltu_correct: flush=%b br=%0d mis=%0d required 0 %0d %0d",
               bus.o_flush, bus.o_br_cnt, bus.o_mispred_cnt, m_br, m_mis);
    end
    set_ex(1, 1, 0, 3'b101, 32'h204, 32'h300, 0, 1, 0);
    #1;
    n_cmp++;
    if (bus.o_br_unsigned !== 1'b0) begin
      n_bad++; $display("FAIL bge_unsigned: got %b required 0", bus.o_br_unsigned);
    end
    tick();
    n_cmp++;
    if (bus.o_flush !== 1'b0 || bus.o_redirect_valid !== 1'b0 || bus.o_br_cnt !== m_br ||
        bus.o_mispred_cnt !== m_mis) begin
      n_bad++;
      $display("FAIL bge_not_taken: flush=%b rv=%b br=%0d mis=%0d required 0 0 %0d %0d",
               bus.o_flush, bus.o_redirect_valid, bus.o_br_cnt, bus.o_mispred_cnt, m_br, m_mis);
    end
    idle();
  endtask

  task automatic test_stall();
    logic [31:0] br0;
    br0 = m_br;
    set_ex(1, 1, 1, 3'b001, 32'h300, 32'h40, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.o_flush !== 1'b0 || bus.o_br_cnt !== br0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: flush=%b br=%0d required 0 %0d", i, bus.o_flush, bus.o_br_cnt, br0);
      end
    end
    bus.i_ex_stall = 1'b0;
    tick();
    n_cmp++;
    if (bus.o_flush !== 1'b1 || bus.o_redirect_pc !== 32'h40 || bus.o_br_cnt !== br0 + 32'd1) begin
      n_bad++;
      $display("FAIL stall_release: flush=%b rpc=%h br=%0d required 1 00000040 %0d",
               bus.o_flush, bus.o_redirect_pc, bus.o_br_cnt, br0 + 32'd1);
    end
    idle();
    tick();
    n_cmp++;
    if (bus.o_flush !== 1'b0 || bus.o_br_cnt !== br0 + 32'd1) begin
      n_bad++;
      $display("FAIL stall_single: flush=%b br=%0d required 0 %0d", bus.o_flush, bus.o_br_cnt, br0 + 32'd1);
    end
  endtask

  task automatic test_saturate_illegal();
    bus.i_if_pc = 32'h10;
    for (int i = 0; i < 4; i++) begin
      set_ex(1, 1, 0, 3'b000, 32'h10, 32'h20, 1, 0, 1);
      tick();
    end
    n_cmp++;
    if (bus.o_if_pred_taken !== 1'b1 || m_bht[4] != 3) begin
      n_bad++; $display("FAIL sat_taken: got %b required 1", bus.o_if_pred_taken);
    end
    set_ex(1, 1, 0, 3'b000, 32'h10, 32'h20, 0, 0, 0);
    tick();
    n_cmp++;
    if (bus.o_if_pred_taken !== 1'b1) begin
      n_bad++; $display("FAIL sat_one_down: got %b required 1", bus.o_if_pred_taken);
    end
    set_ex(1, 1, 0, 3'b011, 32'h10, 32'h20, 0, 1, 1);
    tick();
    n_cmp++;
    if (bus.o_illegal !== 1'b1 || bus.o_flush !== 1'b0 || bus.o_if_pred_taken !== 1'b0 ||
        bus.o_br_cnt !== m_br) begin
      n_bad++;
      $display("FAIL illegal: ill=%b flush=%b pred=%b br=%0d required 1 0 0 %0d",
               bus.o_illegal, bus.o_flush, bus.o_if_pred_taken, bus.o_br_cnt, m_br);
    end
    idle();
    tick();
    n_cmp++;
    if (bus.o_illegal !== 1'b0) begin
      n_bad++; $display("FAIL illegal_pulse: got %b required 0", bus.o_illegal);
    end
  endtask

  task automatic test_reset_mid_flush();
    int bad_pred;
    set_ex(1, 1, 0, 3'b000, 32'h100, 32'h180, 0, 0, 1);
    tick();
    idle();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.o_flush !== 1'b0 || bus.o_redirect_valid !== 1'b0 || bus.o_br_cnt !== 32'd0 ||
        bus.o_mispred_cnt !== 32'd0 || bus.o_redirect_pc !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_flush: flush=%b rv=%b br=%0d mis=%0d rpc=%h required all 0",
               bus.o_flush, bus.o_redirect_valid, bus.o_br_cnt, bus.o_mispred_cnt, bus.o_redirect_pc);
    end
    bad_pred = 0;
    for (int i = 0; i < 64; i++) begin
      bus.i_if_pc = 32'(i) << 2;
      #1;
      if (bus.o_if_pred_taken !== 1'b0) bad_pred++;
    end
    n_cmp++;
    if (bad_pred != 0) begin
      n_bad++; $display("FAIL reset_bht: %0d entries predict taken, required 0", bad_pred);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    set_ex(1, 1, 0, 3'b000, 32'h100, 32'h1234, 0, 0, 1);
    tick();
    idle();
    tick();
    set_ex(1, 1, 0, 3'b001, 32'hFFFF_FFFC, 32'h800, 1, 0, 1);
    tick();
    n_cmp++;
    if (bus.o_flush !== 1'b1 || bus.o_redirect_pc !== 32'h0000_0000 || bus.o_mispred_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL pc_wrap: flush=%b rpc=%h mis=%0d required 1 00000000 2",
               bus.o_flush, bus.o_redirect_pc, bus.o_mispred_cnt);
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pc, got_pc;
    for (int n = 0; n < 400; n++) begin
      pc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      set_ex($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
             3'($urandom_range(0, 7)), pc, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      bus.i_if_pc = (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'hFFFF_FF00);
      #1;
      n_cmp++;
      if (bus.o_br_unsigned !== bus.i_ex_funct3[1] ||
          bus.o_if_pred_taken !== (m_bht[idx_of(bus.i_if_pc)] >= 2)) begin
        n_bad++;
        $display("FAIL rand_comb[%0d]: uns=%b pred=%b required %b %b", n, bus.o_br_unsigned,
                 bus.o_if_pred_taken, bus.i_ex_funct3[1], m_bht[idx_of(bus.i_if_pc)] >= 2);
      end
      tick();
      if (e_flush) exp_q.push_back(e_rpc);
      n_cmp++;
      if (bus.o_flush !== e_flush || bus.o_redirect_valid !== e_flush || bus.o_illegal !== e_ill ||
          bus.o_br_cnt !== m_br || bus.o_mispred_cnt !== m_mis) begin
        n_bad++;
        $display("FAIL rand_seq[%0d]: flush=%b rv=%b ill=%b br=%0d mis=%0d required %b %b %b %0d %0d",
                 n, bus.o_flush, bus.o_redirect_valid, bus.o_illegal, bus.o_br_cnt,
                 bus.o_mispred_cnt, e_flush, e_flush, e_ill, m_br, m_mis);
      end
      if (bus.o_redirect_valid === 1'b1 && exp_q.size() > 0) begin
        got_pc = exp_q.pop_front();
        n_cmp++;
        if (bus.o_redirect_pc !== got_pc) begin
          n_bad++;
          $display("FAIL rand_rpc[%0d]: got %h required %h", n, bus.o_redirect_pc, got_pc);
        end
      end
    end
    idle();
    tick();
  endtask

  // Sequence and final report
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_beq_mispredict();
    test_lt_ge();
    test_stall();
    test_saturate_illegal();
    test_reset_mid_flush();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
